// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download router: FSM states and the registered remap result.
package rom_dl_pkg;

    localparam int RD_NREG_MAX = 8;
    localparam int RD_ADDR_MAX = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Word address is carried at full width and trimmed to SAW where it is used.
    typedef struct packed {
        logic                   vld;
        logic [2:0]             region;
        logic                   port;
        logic [RD_ADDR_MAX-1:0] a;
        logic [1:0]             ds;
    } remap_t;

endpackage

// File: rtl/rom_dl_remap.sv
// Combinational region select and byte-to-SDRAM-word mapping for one ioctl byte address.
module rom_dl_remap
    import rom_dl_pkg::*;
#(
    parameter int                  NREG       = 2,
    parameter int                  AW         = 25,
    parameter int                  SAW        = 23,
    parameter logic [NREG*AW-1:0]  REG_BASE   = {25'h0C000, 25'h00000},
    parameter logic [NREG*SAW-1:0] REG_SDBASE = {23'h0, 23'h0},
    parameter logic [NREG-1:0]     REG_PORT   = 2'b10,
    parameter logic [NREG-1:0]     REG_MERGE  = 2'b10,
    parameter int                  MERGE_BIT  = 14
) (
    input  logic [AW-1:0] addr_i,
    output remap_t        map_o
);

    localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [AW-1:0] LANE_MASK = {AW{1'b1}} >> (AW - MERGE_BIT);

    if (NREG < 1 || NREG > RD_NREG_MAX) begin : g_bad_nreg
        $error("rom_dl_remap: NREG out of range");
    end

    logic          hit_w;
    logic [SW-1:0] sel_w;
    logic [AW-1:0] off_w;
    logic [AW-1:0] merged_w;
    logic [SAW-1:0] lin_w;
    logic [SAW-1:0] word_w;

    // Bases ascend with index, so the last match is the highest region.
    always_comb begin
        hit_w = 1'b0;
        sel_w = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_i >= REG_BASE[i*AW +: AW]) begin
                hit_w = 1'b1;
                sel_w = SW'(i);
            end
        end
    end

    assign off_w    = addr_i - REG_BASE[sel_w*AW +: AW];
    // Merge mode squeezes the lane bit out of the offset.
    assign merged_w = ((off_w >> (MERGE_BIT + 1)) << MERGE_BIT) | (off_w & LANE_MASK);
    assign lin_w    = REG_MERGE[sel_w] ? SAW'(merged_w) : SAW'(off_w >> 1);
    assign word_w   = REG_SDBASE[sel_w*SAW +: SAW] + lin_w;

    always_comb begin
        map_o        = '0;
        map_o.vld    = hit_w;
        map_o.region = 3'(sel_w);
        map_o.port   = REG_PORT[sel_w];
        map_o.a      = RD_ADDR_MAX'(word_w);
        map_o.ds     = REG_MERGE[sel_w] ? {~off_w[MERGE_BIT], off_w[MERGE_BIT]}
                                        : {off_w[0], ~off_w[0]};
    end

endmodule

// File: rtl/rom_dl_router.sv
// ROM download router: data_io byte stream to two toggle-handshake SDRAM ports, plus load/reset control.
// Optional running checksum of one region is enabled by defining ROM_DL_CHECKSUM_EN.
module rom_dl_router
    import rom_dl_pkg::*;
#(
    parameter int                  NREG       = 2,
    parameter int                  AW         = 25,
    parameter int                  SAW        = 23,
    parameter logic [NREG*AW-1:0]  REG_BASE   = {25'h0C000, 25'h00000},
    parameter logic [NREG*SAW-1:0] REG_SDBASE = {23'h0, 23'h0},
    parameter logic [NREG-1:0]     REG_PORT   = 2'b10,
    parameter logic [NREG-1:0]     REG_MERGE  = 2'b10,
    parameter int                  MERGE_BIT  = 14,
    parameter logic [7:0]          IDX        = 8'd0,
    parameter int                  RST_HOLD   = 16
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           ioctl_downl,
    input  logic [7:0]     ioctl_index,
    input  logic           ioctl_wr,
    input  logic [AW-1:0]  ioctl_addr,
    input  logic [7:0]     ioctl_dout,
    input  logic           user_reset,
    output logic           port1_req,
    input  logic           port1_ack,
    output logic [SAW-1:0] port1_a,
    output logic [1:0]     port1_ds,
    output logic [15:0]    port1_d,
    output logic           port1_we,
    output logic           port2_req,
    input  logic           port2_ack,
    output logic [SAW-1:0] port2_a,
    output logic [1:0]     port2_ds,
    output logic [15:0]    port2_d,
    output logic           port2_we,
    output logic           rom_loaded,
    output logic           core_reset_n,
    output logic           overflow,
    output logic           busy
`ifdef ROM_DL_CHECKSUM_EN
    ,
    input  logic [2:0]     region_sel_ck,
    output logic [15:0]    checksum
`endif
);

    localparam int HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    remap_t map_w;

    rom_dl_remap #(
        .NREG      (NREG),
        .AW        (AW),
        .SAW       (SAW),
        .REG_BASE  (REG_BASE),
        .REG_SDBASE(REG_SDBASE),
        .REG_PORT  (REG_PORT),
        .REG_MERGE (REG_MERGE),
        .MERGE_BIT (MERGE_BIT)
    ) u_remap (
        .addr_i(ioctl_addr),
        .map_o (map_w)
    );

    state_t state_q, state_d;
    logic   wr_q, downl_q;
    logic   acc_q, acc_d;
    remap_t acc_map_q, acc_map_d;
    logic [7:0] acc_dat_q, acc_dat_d;
    logic   buf_vld_q, buf_vld_d;
    remap_t buf_map_q, buf_map_d;
    logic [7:0] buf_dat_q, buf_dat_d;
    logic   sel_q, sel_d;

    // Index 0 is port1, index 1 is port2.
    logic [1:0]           req_q, req_d;
    logic [1:0][SAW-1:0]  a_q, a_d;
    logic [1:0][1:0]      ds_q, ds_d;
    logic [1:0][15:0]     d_q, d_d;
    logic [1:0]           we_q, we_d;
    logic [1:0]           ack_w;

    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          loaded_q, loaded_d;
    logic [HW-1:0] hold_q, hold_d;

    logic   wr_edge_w, dl_rise_w, dl_fall_w, hold_cond_w;
    logic   issue_w;
    remap_t iss_map_w;
    logic [7:0] iss_dat_w;

    assign ack_w     = {port2_ack, port1_ack};
    assign wr_edge_w = ioctl_wr & ~wr_q;
    assign dl_rise_w = ioctl_downl & ~downl_q;
    assign dl_fall_w = ~ioctl_downl & downl_q;

    assign acc_d     = wr_edge_w & ioctl_downl & (ioctl_index == IDX) & map_w.vld;
    assign acc_map_d = map_w;
    assign acc_dat_d = ioctl_dout;

    always_comb begin
        state_d   = state_q;
        buf_vld_d = buf_vld_q;
        buf_map_d = buf_map_q;
        buf_dat_d = buf_dat_q;
        sel_d     = sel_q;
        req_d     = req_q;
        a_d       = a_q;
        ds_d      = ds_q;
        d_d       = d_q;
        we_d      = we_q;
        ovf_d     = ovf_q;
        issue_w   = 1'b0;
        iss_map_w = acc_map_q;
        iss_dat_w = acc_dat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (buf_vld_q) begin
                    // Buffered byte goes first; a same-cycle accept takes its slot.
                    issue_w   = 1'b1;
                    iss_map_w = buf_map_q;
                    iss_dat_w = buf_dat_q;
                    buf_vld_d = acc_q;
                    buf_map_d = acc_map_q;
                    buf_dat_d = acc_dat_q;
                end else if (acc_q) begin
                    issue_w = 1'b1;
                end
            end
            ST_WAIT: begin
                if (ack_w[sel_q] == req_q[sel_q]) begin
                    state_d = ST_IDLE;
                end
                if (acc_q) begin
                    if (!buf_vld_q) begin
                        buf_vld_d = 1'b1;
                        buf_map_d = acc_map_q;
                        buf_dat_d = acc_dat_q;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue_w) begin
            state_d                = ST_WAIT;
            sel_d                  = iss_map_w.port;
            req_d[iss_map_w.port]  = ~req_q[iss_map_w.port];
            a_d[iss_map_w.port]    = iss_map_w.a[SAW-1:0];
            ds_d[iss_map_w.port]   = iss_map_w.ds;
            d_d[iss_map_w.port]    = {iss_dat_w, iss_dat_w};
            we_d[iss_map_w.port]   = ioctl_downl;
        end
    end

    assign busy = (state_q != ST_IDLE) | buf_vld_q;

    // Core stays in reset until loaded, then for RST_HOLD quiet cycles after any hold condition.
    assign hold_cond_w = user_reset | ~loaded_q | ioctl_downl;

    always_comb begin
        done_d = done_q;
        if (dl_rise_w) begin
            done_d = 1'b0;
        end else if (dl_fall_w) begin
            done_d = 1'b1;
        end
        loaded_d = loaded_q | (done_q & ~busy & ~acc_q);
        if (hold_cond_w) begin
            hold_d = HW'(RST_HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            downl_q   <= 1'b0;
            acc_q     <= 1'b0;
            acc_map_q <= '0;
            acc_dat_q <= '0;
            buf_vld_q <= 1'b0;
            buf_map_q <= '0;
            buf_dat_q <= '0;
            sel_q     <= 1'b0;
            req_q     <= '0;
            a_q       <= '0;
            ds_q      <= '0;
            d_q       <= '0;
            we_q      <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            loaded_q  <= 1'b0;
            hold_q    <= HW'(RST_HOLD);
        end else begin
            state_q   <= state_d;
            wr_q      <= ioctl_wr;
            downl_q   <= ioctl_downl;
            acc_q     <= acc_d;
            acc_map_q <= acc_map_d;
            acc_dat_q <= acc_dat_d;
            buf_vld_q <= buf_vld_d;
            buf_map_q <= buf_map_d;
            buf_dat_q <= buf_dat_d;
            sel_q     <= sel_d;
            req_q     <= req_d;
            a_q       <= a_d;
            ds_q      <= ds_d;
            d_q       <= d_d;
            we_q      <= we_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            loaded_q  <= loaded_d;
            hold_q    <= hold_d;
        end
    end

    assign port1_req    = req_q[0];
    assign port1_a      = a_q[0];
    assign port1_ds     = ds_q[0];
    assign port1_d      = d_q[0];
    assign port1_we     = we_q[0];
    assign port2_req    = req_q[1];
    assign port2_a      = a_q[1];
    assign port2_ds     = ds_q[1];
    assign port2_d      = d_q[1];
    assign port2_we     = we_q[1];
    assign rom_loaded   = loaded_q;
    assign overflow     = ovf_q;
    assign core_reset_n = ~(hold_cond_w | (hold_q != '0));

    logic map_unused;
    assign map_unused = ^{iss_map_w.vld, iss_map_w.region, iss_map_w.a >> SAW};

`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] ck_q, ck_d;

    // Dropped bytes are still summed: the sum follows the accept, not the issue.
    always_comb begin
        ck_d = ck_q;
        if (dl_rise_w) begin
            ck_d = '0;
        end else if (acc_q && (acc_map_q.region == region_sel_ck)) begin
            ck_d = ck_q + {8'h00, acc_dat_q};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            ck_q <= '0;
        end else begin
            ck_q <= ck_d;
        end
    end

    assign checksum = ck_q;
`endif

endmodule
